// File: rtl/sram_step_sequencer.sv
// sram_step_sequencer: step-driven SRAM fill/readback sequencer with cycle-counted strobes.
// Define SRAM_CHECK_EN to add XOR checksums of written vs read words and drive Error.
module sram_step_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int WORDS     = 9,
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         STEP,
    input  logic [DATA_W-1:0]            SW,
    output logic [DATA_W-1:0]            Light,
    output logic [$clog2(WORDS+1)-1:0]   Index,
    output logic                         Busy,
    output logic                         Error,
    output logic [ADDR_W-1:0]            Ram1Addr,
    inout  wire  [DATA_W-1:0]            Ram1Data,
    output logic                         Ram1OE,
    output logic                         Ram1WE,
    output logic                         Ram1EN
);
    localparam int IW   = $clog2(WORDS+1);
    localparam int H    = DATA_W/2;
    localparam int CMAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CW   = $clog2(CMAX+1);

    typedef enum logic [2:0] {IDLE, FILL, DUMP, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] start;
    logic [DATA_W-1:0] wdata;
    logic drive, wr_done, rd_done, last;

    assign Ram1Data = drive ? wdata : 'z;
    assign Busy = !(state inside {IDLE, FILL, DUMP});
    assign last = Index == IW'(WORDS-1);

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        wr_done = 1'b0;
        rd_done = 1'b0;
        case (state)
            IDLE:     state_n = STEP ? FILL : IDLE;
            FILL:     state_n = STEP ? WR_SETUP : FILL;
            DUMP:     state_n = STEP ? RD_SETUP : DUMP;
            WR_SETUP: begin
                state_n = WR_PULSE;
                cnt_n = '0;
            end
            WR_PULSE: begin
                state_n = (cnt == CW'(WE_CYCLES-1)) ? WR_HOLD : WR_PULSE;
                cnt_n = (cnt == CW'(WE_CYCLES-1)) ? cnt : cnt + 1'b1;
            end
            WR_HOLD: begin
                wr_done = 1'b1;
                state_n = last ? DUMP : FILL;
            end
            RD_SETUP: begin
                state_n = RD_WAIT;
                cnt_n = '0;
            end
            RD_WAIT: begin
                rd_done = cnt == CW'(RD_CYCLES-1);
                state_n = rd_done ? (last ? IDLE : DUMP) : RD_WAIT;
                cnt_n = rd_done ? cnt : cnt + 1'b1;
            end
            default:  state_n = IDLE;
        endcase
    end

    // Strobes and bus enable are registered from the next state so the SRAM pins never glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            start <= '0;
            wdata <= '0;
            Ram1Addr <= '0;
            Light <= '0;
            Index <= '0;
            Ram1EN <= 1'b1;
            Ram1OE <= 1'b1;
            Ram1WE <= 1'b1;
            drive <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            Ram1WE <= state_n != WR_PULSE;
            Ram1OE <= state_n != RD_WAIT;
            Ram1EN <= state_n inside {IDLE, FILL, DUMP};
            drive <= state_n inside {WR_SETUP, WR_PULSE, WR_HOLD};
            if (state == IDLE && STEP) begin
                start <= ADDR_W'(SW);
                Light <= SW;
                Index <= '0;
            end
            if (state == FILL && STEP)
                wdata <= SW;
            if ((state == FILL || state == DUMP) && STEP)
                Ram1Addr <= start + ADDR_W'(Index);
            if (wr_done)
                Light <= {Ram1Addr[H-1:0], wdata[H-1:0]};
            if (rd_done)
                Light <= {Ram1Addr[H-1:0], Ram1Data[H-1:0]};
            if (wr_done || rd_done)
                Index <= last ? '0 : Index + 1'b1;
        end
    end

`ifdef SRAM_CHECK_EN
    logic [DATA_W-1:0] wsum, rsum;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wsum <= '0;
            rsum <= '0;
            Error <= 1'b0;
        end else begin
            if (state == IDLE && STEP) begin
                wsum <= '0;
                rsum <= '0;
                Error <= 1'b0;
            end
            if (wr_done)
                wsum <= wsum ^ wdata;
            if (rd_done)
                rsum <= rsum ^ Ram1Data;
            if (rd_done && last)
                Error <= (rsum ^ Ram1Data) != wsum;
        end
    end
`else
    assign Error = 1'b0;
`endif
endmodule
